aes_job_scheduler: RTL and testbench

AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

---
 rtl/aes_job_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_aes_job_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: queues AES encrypt/decrypt jobs in a small FIFO and
// sequences them one at a time through an external SPI AES master
// (reset pulse, select, wait for done, capture, hand result downstream).
// Optional feature: define AES_JOB_TIMEOUT_EN to abort a RUN that lasts
// TIMEOUT_CYC cycles without core_done (result reported with res_err=1).
module aes_job_scheduler #(
    parameter int Nk          = 4,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic              job_mode,
    input  logic [127:0]      job_data,
    input  logic [Nk*32-1:0]  job_key,
    output logic              core_rst,
    output logic              core_sel_enc_n,
    output logic              core_sel_dec_n,
    output logic [127:0]      core_data,
    output logic [Nk*32-1:0]  core_key,
    input  logic              core_done,
    input  logic [127:0]      core_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [127:0]      res_data,
    output logic              res_mode,
    output logic [3:0]        res_tag,
    output logic              res_err
);

    localparam int KW = Nk * 32;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t state, state_nx;

    // ---------------- job FIFO ----------------
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          full, empty, push, pop;
    logic [3:0]    tag_cnt;

    logic          fifo_mode [DEPTH];
    logic [127:0]  fifo_data [DEPTH];
    logic [KW-1:0] fifo_key  [DEPTH];
    logic [3:0]    fifo_tag  [DEPTH];

    logic          head_mode;
    logic [127:0]  head_data;
    logic [KW-1:0] head_key;
    logic [3:0]    head_tag;

    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign job_ready = !full;
    assign push      = job_valid && !full;
    assign pop       = (state == S_CAPTURE);

    assign head_mode = fifo_mode[rd_idx];
    assign head_data = fifo_data[rd_idx];
    assign head_key  = fifo_key[rd_idx];
    assign head_tag  = fifo_tag[rd_idx];

    // FIFO pointers and enqueue tag counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_cnt <= tag_cnt + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mode[wr_idx] <= job_mode;
            fifo_data[wr_idx] <= job_data;
            fifo_key[wr_idx]  <= job_key;
            fifo_tag[wr_idx]  <= tag_cnt;
        end
    end

    // ---------------- RUN timeout ----------------
    logic timeout_hit;

`ifdef AES_JOB_TIMEOUT_EN
    logic [31:0] run_cnt;

    // RUN cycle counter, zero in the first RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= (state == S_RUN) ? run_cnt + 32'd1 : '0;
        end
    end

    assign timeout_hit = (state == S_RUN) && !core_done &&
                         (run_cnt == 32'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------- control FSM ----------------
    logic load_cnt;

    // state register and LOAD length counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            load_cnt <= 1'b0;
        end else begin
            state    <= state_nx;
            load_cnt <= (state == S_LOAD) ? !load_cnt : 1'b0;
        end
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (!empty) state_nx = S_LOAD;
            S_LOAD:    if (load_cnt) state_nx = S_RUN;
            S_RUN:     if (core_done || timeout_hit) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_HOLD;
            S_HOLD:    if (res_ready) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Core-side outputs are registered from the next state so they align
    // with the state they belong to and reset to the "core held" values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rst       <= 1'b1;
            core_sel_enc_n <= 1'b1;
            core_sel_dec_n <= 1'b1;
            core_data      <= '0;
            core_key       <= '0;
        end else begin
            core_rst       <= (state_nx == S_LOAD);
            core_sel_enc_n <= !((state_nx == S_RUN) && !head_mode);
            core_sel_dec_n <= !((state_nx == S_RUN) && head_mode);
            if ((state == S_IDLE) && (state_nx == S_LOAD)) begin
                core_data <= head_data;
                core_key  <= head_key;
            end
        end
    end

    // result registers; data is taken in the cycle done is seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_mode <= 1'b0;
            res_tag  <= '0;
        end else begin
            if ((state == S_RUN) && core_done) begin
                res_data <= core_result;
            end else if (timeout_hit) begin
                res_data <= '0;
            end
            if (state == S_CAPTURE) begin
                res_mode <= head_mode;
                res_tag  <= head_tag;
            end
        end
    end

`ifdef AES_JOB_TIMEOUT_EN
    // error flag: set by an aborted RUN, cleared by a completed one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err <= 1'b0;
        end else if ((state == S_RUN) && core_done) begin
            res_err <= 1'b0;
        end else if (timeout_hit) begin
            res_err <= 1'b1;
        end
    end
`else
    assign res_err = 1'b0;
`endif

    assign res_valid = (state == S_HOLD);

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed self-checking bench for aes_job_scheduler with a behavioural
// stand-in for the SPI AES master (fixed latency, stall control).
module tb_aes_job_scheduler;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] MASK_E = {4{32'hA5A5A5A5}};
    localparam logic [127:0] MASK_D = {4{32'h5A5A5A5A}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic         job_mode = 1'b0;
    logic [127:0] job_data = '0;
    logic [127:0] job_key = '0;
    logic         core_rst, core_sel_enc_n, core_sel_dec_n;
    logic [127:0] core_data, core_key;
    logic         core_done;
    logic [127:0] core_result = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [127:0] res_data;
    logic         res_mode;
    logic [3:0]   res_tag;
    logic         res_err;

    logic         done_m = 1'b0;
    logic         extra_done = 1'b0;
    logic         stall = 1'b0;
    int           mcnt = 0;

    int           tests = 0;
    int           fails = 0;
    logic [3:0]   exp_tag = 4'd0;

    aes_job_scheduler #(.Nk(4), .DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
        .job_data(job_data), .job_key(job_key),
        .core_rst(core_rst), .core_sel_enc_n(core_sel_enc_n),
        .core_sel_dec_n(core_sel_dec_n), .core_data(core_data), .core_key(core_key),
        .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_mode(res_mode), .res_tag(res_tag), .res_err(res_err)
    );

    always #5 clk = ~clk;

    assign core_done = done_m | extra_done;

    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic dec);
        if (!dec && d == PT) return CT;
        if (dec && d == CT) return PT;
        return d ^ (dec ? MASK_D : MASK_E);
    endfunction

    function automatic logic [127:0] jd(input int i);
        return {4{32'h10000000 + 32'(i)}};
    endfunction

    // behavioural AES master: done pulse 3 cycles into a select, unless stalled
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt   <= 0;
            done_m <= 1'b0;
        end else if (!core_sel_enc_n || !core_sel_dec_n) begin
            mcnt        <= mcnt + 1;
            done_m      <= !stall && (mcnt >= 2) && !done_m;
            core_result <= core_fn(core_data, !core_sel_dec_n);
        end else begin
            mcnt   <= 0;
            done_m <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic m, input logic [127:0] d);
        job_mode  = m;
        job_data  = d;
        job_key   = KEY;
        job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        exp_tag   = exp_tag + 4'd1;
    endtask

    task automatic wait_res(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            if (res_valid) ok = 1'b1;
            else step();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++; if ({core_rst, core_sel_enc_n, core_sel_dec_n} !== 3'b111) begin
            fails++; $display("FAIL rst_core_ctrl got %b exp 111", {core_rst, core_sel_enc_n, core_sel_dec_n}); end
        tests++; if (core_data !== '0 || core_key !== '0) begin
            fails++; $display("FAIL rst_core_bus got %h/%h exp 0", core_data, core_key); end
        tests++; if ({res_valid, res_mode, res_err, res_tag} !== 7'd0 || res_data !== '0) begin
            fails++; $display("FAIL rst_result got v%b m%b e%b t%h d%h exp 0", res_valid, res_mode, res_err, res_tag, res_data); end
        tests++; if (job_ready !== 1'b1) begin
            fails++; $display("FAIL rst_job_ready got %b exp 1", job_ready); end
        rst = 1'b0;
        exp_tag = 4'd0;
        step();
        tests++; if (core_rst !== 1'b0) begin
            fails++; $display("FAIL rst_release_core_rst got %b exp 0", core_rst); end
    endtask

    task automatic test_encrypt();
        bit ok;
        push(1'b0, PT);
        tests++; if (core_rst !== 1'b0) begin
            fails++; $display("FAIL lat_idle_cycle core_rst got %b exp 0", core_rst); end
        step();
        tests++; if (core_rst !== 1'b1 || core_data !== PT || core_key !== KEY) begin
            fails++; $display("FAIL lat_load1 got rst%b d%h k%h exp rst1 d%h k%h", core_rst, core_data, core_key, PT, KEY); end
        step();
        tests++; if (core_rst !== 1'b1 || core_sel_enc_n !== 1'b1) begin
            fails++; $display("FAIL lat_load2 got rst%b enc_n%b exp rst1 enc_n1", core_rst, core_sel_enc_n); end
        step();
        tests++; if ({core_rst, core_sel_enc_n, core_sel_dec_n} !== 3'b001) begin
            fails++; $display("FAIL lat_run_sel got %b exp 001", {core_rst, core_sel_enc_n, core_sel_dec_n}); end
        wait_res(20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL enc_res_timeout got 0 exp res_valid"); end
        tests++; if (res_data !== CT || res_mode !== 1'b0 || res_tag !== 4'd0 || res_err !== 1'b0) begin
            fails++; $display("FAIL enc_result got d%h m%b t%h e%b exp d%h m0 t0 e0", res_data, res_mode, res_tag, res_err, CT); end
        tests++; if (core_data !== PT) begin
            fails++; $display("FAIL enc_core_data_stable got %h exp %h", core_data, PT); end
        handshake();
        tests++; if (res_valid !== 1'b0) begin
            fails++; $display("FAIL enc_res_drop got %b exp 0", res_valid); end
    endtask

    task automatic test_decrypt();
        bit ok;
        bit seen;
        seen = 1'b0;
        push(1'b1, CT);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (!core_sel_dec_n) seen = 1'b1;
            else step();
        end
        tests++; if (!seen || core_sel_enc_n !== 1'b1) begin
            fails++; $display("FAIL dec_select got seen%b enc_n%b exp seen1 enc_n1", seen, core_sel_enc_n); end
        wait_res(20, ok);
        tests++; if (!ok || res_data !== PT || res_mode !== 1'b1 || res_tag !== 4'd1) begin
            fails++; $display("FAIL dec_result got v%b d%h m%b t%h exp v1 d%h m1 t1", ok, res_data, res_mode, res_tag, PT); end
        handshake();
    endtask

    task automatic test_full_fifo();
        bit ok;
        logic [3:0] base;
        base  = exp_tag;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (job_ready !== 1'b1) begin
                fails++; $display("FAIL full_ready_before_%0d got %b exp 1", i, job_ready); end
            push(1'b0, jd(i));
        end
        tests++; if (job_ready !== 1'b0) begin
            fails++; $display("FAIL full_ready_after4 got %b exp 0", job_ready); end
        job_mode = 1'b0; job_data = jd(4); job_key = KEY; job_valid = 1'b1;
        repeat (5) step();
        tests++; if (job_ready !== 1'b0) begin
            fails++; $display("FAIL full_ready_held got %b exp 0", job_ready); end
        stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (job_ready) ok = 1'b1;
            else step();
        end
        tests++; if (!ok) begin fails++; $display("FAIL full_ready_return got 0 exp 1"); end
        step();
        job_valid = 1'b0;
        exp_tag = exp_tag + 4'd1;
        for (int k = 0; k < 5; k++) begin
            wait_res(40, ok);
            tests++; if (!ok || res_tag !== base + 4'(k) || res_data !== core_fn(jd(k), 1'b0)) begin
                fails++; $display("FAIL full_order_%0d got v%b t%h d%h exp t%h d%h", k, ok, res_tag, res_data, base + 4'(k), core_fn(jd(k), 1'b0)); end
            handshake();
        end
    endtask

    task automatic test_hold();
        bit ok;
        logic [127:0] d0;
        logic [3:0] t1;
        int bad_v, bad_d, bad_l;
        bad_v = 0; bad_d = 0; bad_l = 0;
        push(1'b0, jd(7));
        wait_res(20, ok);
        d0 = res_data;
        tests++; if (!ok || d0 !== core_fn(jd(7), 1'b0)) begin
            fails++; $display("FAIL hold_first got v%b d%h exp %h", ok, d0, core_fn(jd(7), 1'b0)); end
        t1 = exp_tag;
        push(1'b1, jd(8));
        for (int i = 0; i < 20; i++) begin
            extra_done = (i == 10);
            if (res_valid !== 1'b1) bad_v++;
            if (res_data !== d0) bad_d++;
            if (core_rst !== 1'b0) bad_l++;
            step();
        end
        extra_done = 1'b0;
        tests++; if (bad_v != 0 || bad_d != 0 || bad_l != 0) begin
            fails++; $display("FAIL hold_stable got badv%0d badd%0d badload%0d exp 0", bad_v, bad_d, bad_l); end
        handshake();
        step();
        tests++; if (core_rst !== 1'b1) begin
            fails++; $display("FAIL hold_next_load got %b exp 1", core_rst); end
        wait_res(20, ok);
        tests++; if (!ok || res_tag !== t1 || res_mode !== 1'b1 || res_data !== core_fn(jd(8), 1'b1)) begin
            fails++; $display("FAIL hold_second got v%b t%h m%b d%h exp t%h m1 d%h", ok, res_tag, res_mode, res_data, t1, core_fn(jd(8), 1'b1)); end
        handshake();
        extra_done = 1'b1;
        step();
        step();
        extra_done = 1'b0;
        tests++; if ({res_valid, core_rst, core_sel_enc_n, core_sel_dec_n} !== 4'b0011) begin
            fails++; $display("FAIL idle_done_ignored got %b exp 0011", {res_valid, core_rst, core_sel_enc_n, core_sel_dec_n}); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] dv [3];
        logic [3:0] base;
        int nres, nrst;
        bit c_sent, prev_run;
        dv[0] = jd(10); dv[1] = jd(11); dv[2] = jd(12);
        base = exp_tag;
        nres = 0; nrst = 0; c_sent = 1'b0; prev_run = 1'b0;
        res_ready = 1'b1;
        job_mode = 1'b0; job_key = KEY; job_data = dv[0]; job_valid = 1'b1;
        step();
        job_data = dv[1];
        step();
        job_valid = 1'b0;
        exp_tag = exp_tag + 4'd2;
        for (int i = 0; i < 100 && nres < 3; i++) begin
            if (core_rst) nrst++;
            if (res_valid) begin
                tests++; if (res_tag !== base + 4'(nres) || res_data !== core_fn(dv[nres], 1'b0)) begin
                    fails++; $display("FAIL b2b_res_%0d got t%h d%h exp t%h d%h", nres, res_tag, res_data, base + 4'(nres), core_fn(dv[nres], 1'b0)); end
                nres++;
            end
            if (job_valid) begin
                job_valid = 1'b0;
            end else if (!c_sent && prev_run && core_sel_enc_n && core_sel_dec_n && !core_rst && !res_valid) begin
                job_data = dv[2];
                job_valid = 1'b1;
                c_sent = 1'b1;
                exp_tag = exp_tag + 4'd1;
            end
            prev_run = !core_sel_enc_n || !core_sel_dec_n;
            step();
        end
        res_ready = 1'b0;
        tests++; if (nres != 3 || nrst != 6) begin
            fails++; $display("FAIL b2b_counts got res%0d loadcyc%0d exp res3 loadcyc6", nres, nrst); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int nv, nr;
        nv = 0; nr = 0; ok = 1'b0;
        stall = 1'b1;
        push(1'b0, jd(20));
        push(1'b0, jd(21));
        push(1'b0, jd(22));
        for (int i = 0; i < 10 && !ok; i++) begin
            if (!core_sel_enc_n) ok = 1'b1;
            else step();
        end
        repeat (10) step();
        rst = 1'b1;
        #1;
        tests++; if (!ok || {core_rst, core_sel_enc_n, core_sel_dec_n, res_valid} !== 4'b1110) begin
            fails++; $display("FAIL midrst_outputs got run%b %b exp 1110", ok, {core_rst, core_sel_enc_n, core_sel_dec_n, res_valid}); end
        step();
        rst = 1'b0;
        stall = 1'b0;
        exp_tag = 4'd0;
        tests++; if (job_ready !== 1'b1) begin
            fails++; $display("FAIL midrst_job_ready got %b exp 1", job_ready); end
        for (int i = 0; i < 30; i++) begin
            step();
            if (res_valid) nv++;
            if (core_rst) nr++;
        end
        tests++; if (nv != 0 || nr != 0) begin
            fails++; $display("FAIL midrst_discard got valid%0d load%0d exp 0", nv, nr); end
        push(1'b0, PT);
        wait_res(20, ok);
        tests++; if (!ok || res_tag !== 4'd0 || res_data !== CT) begin
            fails++; $display("FAIL midrst_tag_restart got v%b t%h d%h exp t0 d%h", ok, res_tag, res_data, CT); end
        handshake();
    endtask

`ifdef AES_JOB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        n = 0; ok = 1'b0;
        stall = 1'b1;
        push(1'b0, jd(30));
        for (int i = 0; i < 10 && !ok; i++) begin
            if (!core_sel_enc_n) ok = 1'b1;
            else step();
        end
        while (!core_sel_enc_n && n < 40) begin
            n++;
            step();
        end
        tests++; if (!ok || n != 16) begin
            fails++; $display("FAIL timeout_run_len got %0d exp 16", n); end
        wait_res(5, ok);
        tests++; if (!ok || res_err !== 1'b1 || res_data !== '0) begin
            fails++; $display("FAIL timeout_result got v%b e%b d%h exp v1 e1 d0", ok, res_err, res_data); end
        handshake();
        stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_full_fifo();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
`ifdef AES_JOB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
